// File: rtl/reg_dump_unit_if.sv
// Output stream of reg_dump_unit: one register word plus its {sel, index} tag,
// moved with a valid/ready handshake.
interface reg_dump_unit_if #(
   parameter int DATA_W = 32
);
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [5:0]        out_tag;

   modport master (
      output out_valid,
      output out_data,
      output out_tag,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_data,
      input  out_tag,
      output out_ready
   );
endinterface

// File: rtl/reg_dump_unit.sv
// Post-run register dump: walks the GPR file (then optionally the FPR file)
// through a synchronous read port and streams each word out with its tag.
module reg_dump_unit #(
   parameter int DATA_W   = 32,
   parameter int NUM_GPR  = 32,
   parameter int NUM_FPR  = 32,
   parameter int DUMP_FPR = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              done,
   input  logic              dump_req,
   output logic              rd_en,
   output logic              rd_sel,
   output logic [4:0]        rd_addr,
   input  logic [DATA_W-1:0] gpr_rd_data,
   input  logic [DATA_W-1:0] fpr_rd_data,
   reg_dump_unit_if.master   stream,
   output logic              dump_busy,
   output logic              dump_done
);
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      REQ  = 3'd1,
      CAP  = 3'd2,
      HOLD = 3'd3,
      FIN  = 3'd4
   } state_t;

   localparam logic [4:0] GPR_LAST = 5'(NUM_GPR - 1);
   localparam logic [4:0] FPR_LAST = 5'(NUM_FPR - 1);

   state_t            state_r, state_nxt_s;
   logic [4:0]        idx_r, idx_nxt_s;
   logic              sel_r, sel_nxt_s;
   logic              done_q_r, armed_r;
   logic              trigger_s, fire_s, last_s;
   logic              rd_en_r, rd_sel_r;
   logic [4:0]        rd_addr_r;
   logic              out_valid_r;
   logic [DATA_W-1:0] out_data_r;
   logic [5:0]        out_tag_r;
   logic              dump_busy_r, dump_done_r;

   // armed_r stays low until done has been seen low, so a done level that is
   // already high coming out of reset cannot fake a rising edge.
   assign trigger_s = dump_req | (done & ~done_q_r & armed_r);
   assign fire_s    = out_valid_r & stream.out_ready;

   // Last-word detection for the register currently held in HOLD.
   always_comb begin
      last_s = 1'b0;
      if (sel_r) begin
         last_s = (idx_r == FPR_LAST);
      end else if (DUMP_FPR == 0) begin
         last_s = (idx_r == GPR_LAST);
      end else begin
         last_s = 1'b0;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state and next-index logic.
   always_comb begin
      state_nxt_s = state_r;
      idx_nxt_s   = idx_r;
      sel_nxt_s   = sel_r;
      case (state_r)
         IDLE: begin
            if (trigger_s) begin
               state_nxt_s = REQ;
               idx_nxt_s   = 5'd0;
               sel_nxt_s   = 1'b0;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         REQ:  state_nxt_s = CAP;
         CAP:  state_nxt_s = HOLD;
         HOLD: begin
            if (!fire_s) begin
               state_nxt_s = HOLD;
            end else if (last_s) begin
               state_nxt_s = FIN;
            end else if (!sel_r && (idx_r == GPR_LAST)) begin
               state_nxt_s = REQ;
               sel_nxt_s   = 1'b1;
               idx_nxt_s   = 5'd0;
            end else begin
               state_nxt_s = REQ;
               idx_nxt_s   = idx_r + 5'd1;
            end
         end
         FIN:     state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // Index, edge detector and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx_r       <= 5'd0;
         sel_r       <= 1'b0;
         done_q_r    <= 1'b0;
         armed_r     <= 1'b0;
         rd_en_r     <= 1'b0;
         rd_sel_r    <= 1'b0;
         rd_addr_r   <= 5'd0;
         out_valid_r <= 1'b0;
         out_data_r  <= '0;
         out_tag_r   <= 6'd0;
         dump_busy_r <= 1'b0;
         dump_done_r <= 1'b0;
      end else begin
         idx_r     <= idx_nxt_s;
         sel_r     <= sel_nxt_s;
         done_q_r  <= done;
         armed_r   <= armed_r | ~done;
         rd_en_r   <= (state_nxt_s == REQ);
         rd_sel_r  <= (state_nxt_s == REQ) ? sel_nxt_s : 1'b0;
         rd_addr_r <= (state_nxt_s == REQ) ? idx_nxt_s : 5'd0;
         if (state_r == CAP) begin
            out_data_r  <= sel_r ? fpr_rd_data : gpr_rd_data;
            out_tag_r   <= {sel_r, idx_r};
            out_valid_r <= 1'b1;
         end else if (fire_s) begin
            out_valid_r <= 1'b0;
         end else begin
            out_valid_r <= out_valid_r;
         end
         dump_done_r <= (state_r == FIN);
         if ((state_r == IDLE) && trigger_s) begin
            dump_busy_r <= 1'b1;
         end else if (state_r == FIN) begin
            dump_busy_r <= 1'b0;
         end else begin
            dump_busy_r <= dump_busy_r;
         end
      end
   end

   assign rd_en            = rd_en_r;
   assign rd_sel           = rd_sel_r;
   assign rd_addr          = rd_addr_r;
   assign stream.out_valid = out_valid_r;
   assign stream.out_data  = out_data_r;
   assign stream.out_tag   = out_tag_r;
   assign dump_busy        = dump_busy_r;
   assign dump_done        = dump_done_r;
endmodule

// File: tb/tb_reg_dump_unit.sv
// Scoreboard bench for reg_dump_unit: dut0 dumps GPRs only, dut1 dumps GPRs then FPRs.
module tb_reg_dump_unit;
   logic        clk = 1'b0;
   logic        rst0, rst1, done0, done1, req0, req1;
   logic        rd_en0, rd_sel0, rd_en1, rd_sel1;
   logic [4:0]  rd_addr0, rd_addr1;
   logic [31:0] gpr_rd0, fpr_rd0, gpr_rd1, fpr_rd1;
   logic        busy0, ddone0, busy1, ddone1;
   logic [31:0] gpr_mem [32];
   logic [31:0] fpr_mem [32];
   logic [37:0] q0 [$];
   logic [37:0] q1 [$];
   logic [37:0] item;
   int tests_run = 0, tests_failed = 0;
   int words0 = 0, words1 = 0, dd0 = 0, dd1 = 0;
   logic prev_busy0 = 1'b0, prev_busy1 = 1'b0;

   reg_dump_unit_if #(.DATA_W(32)) s0 ();
   reg_dump_unit_if #(.DATA_W(32)) s1 ();

   reg_dump_unit #(.DATA_W(32), .NUM_GPR(32), .NUM_FPR(32), .DUMP_FPR(0)) dut0 (
      .clk(clk), .rst(rst0), .done(done0), .dump_req(req0),
      .rd_en(rd_en0), .rd_sel(rd_sel0), .rd_addr(rd_addr0),
      .gpr_rd_data(gpr_rd0), .fpr_rd_data(fpr_rd0), .stream(s0.master),
      .dump_busy(busy0), .dump_done(ddone0));

   reg_dump_unit #(.DATA_W(32), .NUM_GPR(32), .NUM_FPR(32), .DUMP_FPR(1)) dut1 (
      .clk(clk), .rst(rst1), .done(done1), .dump_req(req1),
      .rd_en(rd_en1), .rd_sel(rd_sel1), .rd_addr(rd_addr1),
      .gpr_rd_data(gpr_rd1), .fpr_rd_data(fpr_rd1), .stream(s1.master),
      .dump_busy(busy1), .dump_done(ddone1));

   always #5 clk = ~clk;

   // Synchronous-read register files; data is garbage unless rd_en was high last cycle.
   always @(posedge clk) begin
      gpr_rd0 <= rd_en0 ? gpr_mem[rd_addr0] : 32'hDEAD_BEEF;
      fpr_rd0 <= rd_en0 ? fpr_mem[rd_addr0] : 32'hDEAD_BEEF;
      gpr_rd1 <= rd_en1 ? gpr_mem[rd_addr1] : 32'hDEAD_BEEF;
      fpr_rd1 <= rd_en1 ? fpr_mem[rd_addr1] : 32'hDEAD_BEEF;
   end

   task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_gpr(input int which);
      for (int i = 0; i < 32; i++) begin
         if (which == 0) q0.push_back({1'b0, 5'(i), gpr_mem[i]});
         else            q1.push_back({1'b0, 5'(i), gpr_mem[i]});
      end
   endtask

   task automatic push_fpr1();
      for (int i = 0; i < 32; i++) q1.push_back({1'b1, 5'(i), fpr_mem[i]});
   endtask

   task automatic wait_ddone1(input int budget, input string tag);
      int n = 0;
      while (!ddone1 && n < budget) begin
         @(posedge clk); #1; n++;
      end
      check_value(tag, 64'(ddone1), 64'd1);
   endtask

   // dut0 monitor: a word is transferred at the next posedge when valid & ready.
   always @(negedge clk) begin
      if (s0.out_valid) begin
         check_value("sb0_has_word", 64'(q0.size() != 0), 64'd1);
         if (q0.size() != 0) begin
            item = q0[0];
            check_value("w0_tag",  64'(s0.out_tag),  64'(item[37:32]));
            check_value("w0_data", 64'(s0.out_data), 64'(item[31:0]));
            if (s0.out_tag == 6'd1) check_value("gpr1_val", 64'(s0.out_data), 64'h4196_2E14);
            if (s0.out_tag == 6'd2) check_value("gpr2_val", 64'(s0.out_data), 64'd10);
            if (s0.out_ready) begin
               void'(q0.pop_front());
               words0++;
            end
         end
      end
      if (ddone0) begin
         dd0++;
         check_value("ddone0_busy_low", 64'(busy0), 64'd0);
         check_value("ddone0_busy_was_high", 64'(prev_busy0), 64'd1);
      end
      prev_busy0 = busy0;
   end

   // dut1 monitor, also checks stability against the scoreboard head during stalls.
   always @(negedge clk) begin
      if (s1.out_valid) begin
         check_value("sb1_has_word", 64'(q1.size() != 0), 64'd1);
         if (q1.size() != 0) begin
            item = q1[0];
            check_value("w1_tag",  64'(s1.out_tag),  64'(item[37:32]));
            check_value("w1_data", 64'(s1.out_data), 64'(item[31:0]));
            if (s1.out_tag == 6'b1_00011) check_value("fpr3_val", 64'(s1.out_data), 64'h4196_CCCD);
            if (s1.out_ready) begin
               void'(q1.pop_front());
               words1++;
            end
         end
      end
      if (ddone1) begin
         dd1++;
         check_value("ddone1_busy_low", 64'(busy1), 64'd0);
      end
      prev_busy1 = busy1;
   end

   initial begin
      int n, base_w, base_d, stall;
      rst0 = 1'b1; rst1 = 1'b1; done0 = 1'b0; done1 = 1'b0; req0 = 1'b0; req1 = 1'b0;
      s0.out_ready = 1'b0; s1.out_ready = 1'b0;
      for (int i = 0; i < 32; i++) begin
         gpr_mem[i] = 32'hA500_0000 + 32'(i * 7);
         fpr_mem[i] = 32'h3F00_0000 + 32'(i * 13);
      end
      gpr_mem[1] = 32'h4196_2E14; gpr_mem[2] = 32'd10; gpr_mem[3] = 32'd8;
      fpr_mem[3] = 32'h4196_CCCD;
      repeat (3) @(posedge clk);
      #1;
      check_value("rst_valid",  64'(s0.out_valid), 64'd0);
      check_value("rst_data",   64'(s0.out_data),  64'd0);
      check_value("rst_tag",    64'(s0.out_tag),   64'd0);
      check_value("rst_rd_en",  64'(rd_en0),       64'd0);
      check_value("rst_rd_sel", 64'(rd_sel0),      64'd0);
      check_value("rst_rd_adr", 64'(rd_addr0),     64'd0);
      check_value("rst_busy",   64'(busy0),        64'd0);
      check_value("rst_ddone",  64'(ddone1),       64'd0);
      rst0 = 1'b0; rst1 = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // GPR-only dump triggered by done edge; first word 3 cycles after the edge.
      s0.out_ready = 1'b1;
      push_gpr(0);
      done0 = 1'b1;
      n = 0;
      while (!s0.out_valid && n < 10) begin
         @(posedge clk); #1; n++;
      end
      check_value("first_valid_latency", 64'(n), 64'd3);
      check_value("busy_during_dump", 64'(busy0), 64'd1);
      n = 0;
      while (!ddone0 && n < 300) begin
         @(posedge clk); #1; n++;
      end
      check_value("dump0_done_seen", 64'(ddone0), 64'd1);
      @(posedge clk); #1;
      check_value("dump0_words", 64'(words0), 64'd32);
      check_value("dump0_sb_empty", 64'(q0.size()), 64'd0);
      check_value("dump0_ddone_once", 64'(dd0), 64'd1);
      check_value("ddone_one_cycle", 64'(ddone0), 64'd0);

      // GPR+FPR dump by dump_req with ready held high.
      s1.out_ready = 1'b1;
      base_w = words1;
      push_gpr(1); push_fpr1();
      req1 = 1'b1; @(posedge clk); #1; req1 = 1'b0;
      wait_ddone1(400, "dump1_done_seen");
      @(posedge clk); #1;
      check_value("dump1_words", 64'(words1 - base_w), 64'd64);
      check_value("dump1_sb_empty", 64'(q1.size()), 64'd0);

      // Random backpressure with a 10-cycle stall on word 5.
      base_w = words1; stall = 0;
      push_gpr(1); push_fpr1();
      req1 = 1'b1; @(posedge clk); #1; req1 = 1'b0;
      n = 0;
      while (!ddone1 && n < 3000) begin
         if (s1.out_valid && (words1 - base_w) == 5 && stall < 10) begin
            s1.out_ready = 1'b0; stall++;
         end else begin
            s1.out_ready = 1'($urandom_range(0, 1));
         end
         @(posedge clk); #1; n++;
      end
      check_value("rand_done_seen", 64'(ddone1), 64'd1);
      check_value("rand_stall_len", 64'(stall), 64'd10);
      @(posedge clk); #1;
      check_value("rand_words", 64'(words1 - base_w), 64'd64);
      check_value("rand_sb_empty", 64'(q1.size()), 64'd0);

      // done held high: one dump; mid-dump dump_req ignored; later dump_req starts another.
      s1.out_ready = 1'b1;
      base_d = dd1;
      push_gpr(1); push_fpr1();
      done1 = 1'b1;
      for (int c = 0; c < 260; c++) begin
         req1 = (c == 50);
         @(posedge clk); #1;
      end
      req1 = 1'b0;
      check_value("held_done_one_dump", 64'(dd1 - base_d), 64'd1);
      check_value("held_done_sb_empty", 64'(q1.size()), 64'd0);
      check_value("held_done_idle", 64'(busy1), 64'd0);
      push_gpr(1); push_fpr1();
      req1 = 1'b1; @(posedge clk); #1; req1 = 1'b0;
      wait_ddone1(400, "second_dump_done");
      @(posedge clk); #1;
      check_value("second_dump_count", 64'(dd1 - base_d), 64'd2);
      check_value("second_dump_sb_empty", 64'(q1.size()), 64'd0);

      // Reset while holding word 10, done still high.
      base_w = words1; base_d = dd1;
      push_gpr(1); push_fpr1();
      req1 = 1'b1; @(posedge clk); #1; req1 = 1'b0;
      n = 0;
      while (!(s1.out_valid && (words1 - base_w) == 10) && n < 200) begin
         @(posedge clk); #1; n++;
      end
      s1.out_ready = 1'b0;
      check_value("reached_word10", 64'(s1.out_valid), 64'd1);
      rst1 = 1'b1; @(posedge clk); #1; rst1 = 1'b0;
      check_value("abort_valid", 64'(s1.out_valid), 64'd0);
      check_value("abort_busy",  64'(busy1),        64'd0);
      check_value("abort_ddone", 64'(ddone1),       64'd0);
      q1.delete();
      s1.out_ready = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check_value("no_dump_done_held", 64'(busy1), 64'd0);
      check_value("no_ddone_after_abort", 64'(dd1 - base_d), 64'd0);
      done1 = 1'b0; repeat (2) @(posedge clk); #1;
      base_w = words1;
      push_gpr(1); push_fpr1();
      done1 = 1'b1;
      wait_ddone1(400, "retrigger_done");
      @(posedge clk); #1;
      check_value("retrigger_words", 64'(words1 - base_w), 64'd64);
      check_value("retrigger_sb_empty", 64'(q1.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
